// File: rtl/frontend_pkg.sv
// Shared front-end types and constants.
//   fetch_t       : {instruction, pc} entry pushed into the instruction queue
//   fetch_state_t : fetch sequencer states
//   DEFAULT_RESET_PC / FETCH_BYTES : reset fetch address and PC step per word
package frontend_pkg;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1ECE_B000;
    localparam logic [31:0] FETCH_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_credit_counter.sv
// Credit counter tracking free instruction-queue slots.
//   clk, rst  : clock, synchronous active-high reset (count = depth)
//   inc       : a slot was freed (queue dequeue)
//   dec       : a slot was reserved (fetch issued)
//   load_max  : restore all credits (queue flush); overrides inc/dec
//   nonzero   : at least one credit available
module fetch_credit_counter #(
    parameter int unsigned IQUEUE_INDEX_WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic load_max,
    output logic nonzero
);

    localparam logic [IQUEUE_INDEX_WIDTH:0] CREDIT_MAX = {1'b1, {IQUEUE_INDEX_WIDTH{1'b0}}};

    logic [IQUEUE_INDEX_WIDTH:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || load_max) begin
            count_q <= CREDIT_MAX;
        end else if (inc && !dec) begin
            // Saturate at depth; a spurious dequeue must not wrap the count.
            if (count_q != CREDIT_MAX) begin
                count_q <= count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign nonzero = (count_q != '0);

endmodule

// File: rtl/fetch_controller.sv
// Front-end fetch sequencer between the PC, the instruction memory port and the
// instruction queue. One word-aligned fetch outstanding at a time, throttled by
// queue credits; redirects flush the queue and squash the in-flight fetch.
//   clk, rst             : clock, synchronous active-high reset
//   redirect/redirect_pc : back-end redirect pulse and target (bits [1:0] dropped)
//   stall                : blocks new issues only
//   imem_addr/imem_rmask : request address and one-cycle 4'hF read strobe
//   imem_rdata/imem_resp : returned word and its one-cycle strobe
//   iq_enq/enq_entry     : queue push of {instruction, pc}
//   iq_deq               : queue dequeue by decode (frees a credit)
//   iq_flush             : one-cycle queue clear
module fetch_controller
    import frontend_pkg::*;
#(
    parameter int unsigned IQUEUE_INDEX_WIDTH = 2,
    parameter logic [31:0] RESET_PC           = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        iq_enq,
    output fetch_t      enq_entry,
    input  logic        iq_deq,
    output logic        iq_flush
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fetch_pc_q;
    logic         credit_ok;
    logic         issue;
    logic         accept;

    assign issue  = !rst && (state_q == IDLE) && !redirect && !stall && credit_ok;
    // Response is pushed in the cycle it arrives unless a redirect kills it.
    assign accept = !rst && (state_q == WAIT) && imem_resp && !redirect;

    always_comb begin
        imem_addr  = '0;
        imem_rmask = 4'h0;
        iq_enq     = 1'b0;
        enq_entry  = '0;
        iq_flush   = !rst && redirect;
        if (issue) begin
            imem_addr  = pc_q;
            imem_rmask = 4'hF;
        end
        if (accept) begin
            iq_enq                = 1'b1;
            enq_entry.instruction = imem_rdata;
            enq_entry.pc          = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
        end else if (redirect) begin
            pc_q <= redirect_pc & ~32'd3;
            unique case (state_q)
                // Without a response this cycle the squashed one is still owed.
                WAIT:    state_q <= imem_resp ? IDLE : DRAIN;
                DRAIN:   state_q <= imem_resp ? IDLE : DRAIN;
                default: state_q <= IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        fetch_pc_q <= pc_q;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp) begin
                        pc_q    <= fetch_pc_q + FETCH_BYTES;
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_resp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_credit_counter #(
        .IQUEUE_INDEX_WIDTH(IQUEUE_INDEX_WIDTH)
    ) u_credits (
        .clk      (clk),
        .rst      (rst),
        .inc      (iq_deq),
        .dec      (issue),
        .load_max (redirect && !rst),
        .nonzero  (credit_ok)
    );

endmodule

// File: tb/tb_fetch_controller.sv
`timescale 1ns/1ps
module tb_fetch_controller;
    import frontend_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h1ECE_B000;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, iq_deq, imem_resp;
    logic [31:0] redirect_pc, imem_rdata, imem_addr;
    logic [3:0]  imem_rmask;
    logic        iq_enq, iq_flush;
    fetch_t      enq_entry;

    fetch_controller #(
        .IQUEUE_INDEX_WIDTH(2),
        .RESET_PC(RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .iq_enq     (iq_enq),
        .enq_entry  (enq_entry),
        .iq_deq     (iq_deq),
        .iq_flush   (iq_flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Transaction-level reference: next PC, free credits, queue occupancy and
    // whether a live or squashed fetch is owed by memory.
    logic [31:0] m_pc, m_fpc;
    int          m_credits, m_occ;
    bit          m_out, m_squash;
    bit          e_issue, e_enq, e_flush;
    fetch_t      e_entry;

    // Observation logs for directed scenarios.
    logic [31:0] issue_addr_q[$];
    int          issue_cyc_q[$];
    logic [31:0] enq_pc_q[$];
    int          n_flush;

    // Memory model.
    int          mem_lat = 1;
    bit          mem_rand_lat = 1'b0;
    bit          mem_pending = 1'b0;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    initial begin
        imem_resp  = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_resp  = 1'b0;
            imem_rdata = $urandom;
            if (mem_pending) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt <= 0) begin
                    imem_resp   = 1'b1;
                    imem_rdata  = mem_word(mem_addr);
                    mem_pending = 1'b0;
                end
            end
            @(negedge clk);
            if (imem_rmask == 4'hF) begin
                mem_pending = 1'b1;
                mem_addr    = imem_addr;
                mem_cnt     = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
            end
        end
    end

    // Per-cycle scoreboard against the reference model.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (rst) begin
            e_issue = 1'b0;
            e_enq   = 1'b0;
            e_flush = 1'b0;
        end else begin
            e_flush = redirect;
            e_enq   = m_out && imem_resp && !redirect;
            e_issue = !m_out && !m_squash && !redirect && !stall && (m_credits > 0);
        end
        e_entry.instruction = mem_word(m_fpc);
        e_entry.pc          = m_fpc;

        checks++;
        if (imem_rmask !== (e_issue ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL rmask cyc %0d: got %h want %h", cycle, imem_rmask,
                     e_issue ? 4'hF : 4'h0);
        end
        if (e_issue) begin
            checks++;
            if (imem_addr !== m_pc) begin
                errors++;
                $display("FAIL imem_addr cyc %0d: got %h want %h", cycle, imem_addr, m_pc);
            end
        end
        checks++;
        if (iq_enq !== e_enq) begin
            errors++;
            $display("FAIL iq_enq cyc %0d: got %b want %b", cycle, iq_enq, e_enq);
        end
        if (e_enq) begin
            checks++;
            if (enq_entry !== e_entry) begin
                errors++;
                $display("FAIL enq_entry cyc %0d: got %h want %h", cycle, enq_entry, e_entry);
            end
        end
        checks++;
        if (iq_flush !== e_flush) begin
            errors++;
            $display("FAIL iq_flush cyc %0d: got %b want %b", cycle, iq_flush, e_flush);
        end
        if (rst) begin
            checks++;
            if (imem_addr !== '0 || enq_entry !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: addr %h entry %h want 0", cycle,
                         imem_addr, enq_entry);
            end
        end

        if (imem_rmask == 4'hF) begin
            issue_addr_q.push_back(imem_addr);
            issue_cyc_q.push_back(cycle);
        end
        if (iq_enq) enq_pc_q.push_back(enq_entry.pc);
        if (iq_flush) n_flush++;

        if (rst) begin
            m_pc      = RPC;
            m_credits = DEPTH;
            m_occ     = 0;
            m_out     = 1'b0;
            m_squash  = 1'b0;
        end else if (redirect) begin
            m_pc      = redirect_pc & ~32'd3;
            m_credits = DEPTH;
            m_occ     = 0;
            m_squash  = (m_out || m_squash) && !imem_resp;
            m_out     = 1'b0;
        end else begin
            if (e_enq) begin
                m_pc  = m_fpc + 32'd4;
                m_out = 1'b0;
                m_occ++;
            end
            if (m_squash && imem_resp) m_squash = 1'b0;
            if (iq_deq) begin
                m_occ--;
                if (m_credits < DEPTH) m_credits++;
            end
            if (e_issue) begin
                m_out = 1'b1;
                m_fpc = m_pc;
                m_credits--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        issue_addr_q.delete();
        issue_cyc_q.delete();
        enq_pc_q.delete();
        n_flush = 0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic test_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hDEAD_BEEF;
        repeat (3) begin
            tick();
            #1;
            checks++;
            if (imem_rmask !== 4'h0 || iq_flush !== 1'b0 || iq_enq !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: rmask %h flush %b enq %b want 0 0 0", imem_rmask,
                         iq_flush, iq_enq);
            end
        end
        redirect = 1'b0;
        tick();
        clear_logs();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RPC) begin
            errors++;
            $display("FAIL first_issue: rmask %h addr %h want F %h", imem_rmask, imem_addr, RPC);
        end
    endtask

    task automatic test_fill();
        repeat (30) tick();
        checks++;
        if (issue_addr_q.size() != 4 || enq_pc_q.size() != 4) begin
            errors++;
            $display("FAIL fill_count: issues %0d enqs %0d want 4 4", issue_addr_q.size(),
                     enq_pc_q.size());
        end
        for (int i = 0; i < enq_pc_q.size() && i < 4; i++) begin
            checks++;
            if (enq_pc_q[i] !== RPC + 32'(4 * i)) begin
                errors++;
                $display("FAIL fill_pc[%0d]: got %h want %h", i, enq_pc_q[i], RPC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_one_deq();
        clear_logs();
        iq_deq = 1'b1;
        tick();
        iq_deq = 1'b0;
        repeat (10) tick();
        checks++;
        if (issue_addr_q.size() != 1 || enq_pc_q.size() != 1) begin
            errors++;
            $display("FAIL one_deq_count: issues %0d enqs %0d want 1 1", issue_addr_q.size(),
                     enq_pc_q.size());
        end else begin
            checks++;
            if (issue_addr_q[0] !== RPC + 32'd16 || enq_pc_q[0] !== RPC + 32'd16) begin
                errors++;
                $display("FAIL one_deq_pc: issue %h enq %h want %h", issue_addr_q[0],
                         enq_pc_q[0], RPC + 32'd16);
            end
        end
    endtask

    task automatic test_redirect_wait();
        int r;
        mem_lat = 4;
        do_redirect(32'h0000_1000);
        tick();
        clear_logs();
        r = cycle + 1;
        do_redirect(32'h0000_0803);
        repeat (40) tick();
        checks++;
        if (n_flush != 1) begin
            errors++;
            $display("FAIL rw_flush: got %0d pulses want 1", n_flush);
        end
        checks++;
        if (issue_addr_q.size() != 4) begin
            errors++;
            $display("FAIL rw_credits: got %0d issues want 4", issue_addr_q.size());
        end else begin
            checks++;
            if (issue_addr_q[0] !== 32'h0000_0800 || issue_cyc_q[0] != r + 4) begin
                errors++;
                $display("FAIL rw_restart: addr %h cyc %0d want 00000800 %0d", issue_addr_q[0],
                         issue_cyc_q[0], r + 4);
            end
        end
        checks++;
        if (enq_pc_q.size() == 0 || enq_pc_q[0] !== 32'h0000_0800) begin
            errors++;
            $display("FAIL rw_squash: enqs %0d first %h want first 00000800", enq_pc_q.size(),
                     enq_pc_q.size() ? enq_pc_q[0] : 32'h0);
        end
    endtask

    task automatic test_redirect_resp();
        logic [31:0] target;
        bit          seen;
        mem_lat = 2;
        seen    = 1'b0;
        do_redirect(32'h0000_2000);
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = imem_resp;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rr_timeout: no imem_resp within 10 cycles");
        end
        clear_logs();
        target      = $urandom;
        redirect    = 1'b1;
        redirect_pc = target;
        #1;
        checks++;
        if (iq_enq !== 1'b0 || iq_flush !== 1'b1) begin
            errors++;
            $display("FAIL rr_same_cycle: enq %b flush %b want 0 1", iq_enq, iq_flush);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== (target & ~32'd3)) begin
            errors++;
            $display("FAIL rr_restart: rmask %h addr %h want F %h", imem_rmask, imem_addr,
                     target & ~32'd3);
        end
        repeat (5) tick();
        checks++;
        if (enq_pc_q.size() != 1 || enq_pc_q[0] !== (target & ~32'd3)) begin
            errors++;
            $display("FAIL rr_enq: enqs %0d first %h want 1 %h", enq_pc_q.size(),
                     enq_pc_q.size() ? enq_pc_q[0] : 32'h0, target & ~32'd3);
        end
    endtask

    task automatic test_stall();
        mem_lat = 3;
        do_redirect(32'h0000_3000);
        tick();
        stall = 1'b1;
        clear_logs();
        repeat (8) tick();
        checks++;
        if (enq_pc_q.size() != 1 || issue_addr_q.size() != 0) begin
            errors++;
            $display("FAIL stall_hold: enqs %0d issues %0d want 1 0", enq_pc_q.size(),
                     issue_addr_q.size());
        end else begin
            checks++;
            if (enq_pc_q[0] !== 32'h0000_3000) begin
                errors++;
                $display("FAIL stall_enq_pc: got %h want 00003000", enq_pc_q[0]);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h0000_3004) begin
            errors++;
            $display("FAIL stall_release: rmask %h addr %h want F 00003004", imem_rmask,
                     imem_addr);
        end
        repeat (10) tick();
    endtask

    task automatic test_deq_coincident();
        int n;
        n       = 0;
        mem_lat = 1;
        do_redirect(32'h0000_4000);
        clear_logs();
        for (int k = 0; k < 40 && n < 3; k++) begin
            tick();
            if (iq_enq) n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL dc_timeout: got %0d enqs want 3", n);
        end
        tick();
        iq_deq = 1'b1;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h0000_400C) begin
            errors++;
            $display("FAIL dc_issue: rmask %h addr %h want F 0000400c", imem_rmask, imem_addr);
        end
        tick();
        iq_deq = 1'b0;
        repeat (10) tick();
        checks++;
        if (issue_addr_q.size() != 5 || issue_addr_q[issue_addr_q.size() - 1] !== 32'h0000_4010)
        begin
            errors++;
            $display("FAIL dc_follow: issues %0d last %h want 5 00004010", issue_addr_q.size(),
                     issue_addr_q.size() ? issue_addr_q[issue_addr_q.size() - 1] : 32'h0);
        end
    endtask

    task automatic test_random();
        mem_rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 250) begin
                // One-cycle reset with a fetch possibly in flight; the stall lets
                // the late response land while idle.
                rst      = 1'b1;
                redirect = 1'b0;
                iq_deq   = 1'b0;
                tick();
                rst   = 1'b0;
                stall = 1'b1;
                repeat (6) tick();
            end
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom;
            stall       = ($urandom_range(0, 3) == 0);
            iq_deq      = (m_occ > 0) && ($urandom_range(0, 1) == 1);
            tick();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        iq_deq   = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        iq_deq      = 1'b0;
        n_flush     = 0;
        test_reset();
        test_fill();
        test_one_deq();
        test_redirect_wait();
        test_redirect_resp();
        test_stall();
        test_deq_coincident();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
